multicycle_control: RTL
=======================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameters: none; state encoding is fixed by REQ-011.
REQ-002 clk  in  1  single system clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 op  in  6  instr[31:26] from instruction register; stable from DECODE until return to FETCH.
REQ-005 funct  in  6  instr[5:0]; used only when op=000000.
REQ-006 zero  in  1  ALU zero flag, valid in the same cycle.
REQ-007 pcen  out  1  PC load enable.
REQ-008 iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca  out  1 each  datapath controls.
REQ-009 alusrcb, pcsrc  out  2 each  mux selects; alucontrol  out  3  ALU operation.
REQ-010 state  out  4  current FSM state, for debug and bench checking.

Function
REQ-011 State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11; codes 12-15 go to FETCH on the next edge.
REQ-012 Opcodes: lw=100011, sw=101011, R-type=000000, beq=000100, bne=000101, addi=001000, j=000010.
REQ-013 Transitions:
- FETCH->DECODE.
- DECODE->MEMADR (lw/sw), EXECUTE (R), BRANCH (beq/bne), ADDIEX (addi), JUMP (j); any other op goes to FETCH.
- MEMADR->MEMRD (lw) or MEMWR (sw).
- MEMRD->MEMWB; EXECUTE->ALUWB; ADDIEX->ADDIWB.
- MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH, JUMP->FETCH.
REQ-014 Outputs are Moore-decoded from state; any output not listed for a state is 0.
- FETCH: irwrite=1, pcwrite=1, alusrcb=01, aluop=00.
- DECODE: alusrcb=11, aluop=00.
- MEMADR and ADDIEX: alusrca=1, alusrcb=10, aluop=00.
- MEMRD: iord=1.
- MEMWB: memtoreg=1, regwrite=1.
- MEMWR: iord=1, memwrite=1.
- EXECUTE: alusrca=1, alusrcb=00, aluop=10.
- ALUWB: regdst=1, regwrite=1.
- ADDIWB: regwrite=1.
- BRANCH: alusrca=1, aluop=01, pcsrc=01, branch=1.
- JUMP: pcsrc=10, pcwrite=1.
REQ-015 pcen = pcwrite | (branch & (zero XOR (op==bne))); combinational in zero.
REQ-016 alucontrol decode:
- aluop=00 -> 010 (add); aluop=01 -> 110 (sub).
- aluop=10, by funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111; any other funct -> 010.
REQ-017 Cycles per instruction, FETCH inclusive: lw 5; sw, R-type, addi 4; beq, bne, j 3; undefined op 2.
REQ-018 memwrite and regwrite are never both 1 in the same cycle; irwrite is 1 only in FETCH.

Reset
REQ-019 While reset=1, the state register loads FETCH on each rising edge.
REQ-020 While reset=1, all outputs are forced to 0 combinationally, state excepted, so no spurious writes occur mid-instruction.
REQ-021 In the first cycle after reset falls, state=FETCH, irwrite=1, pcen=1.
REQ-022 Reset asserted in any state, including mid-lw or in MEMWR, abandons the instruction with no further memwrite or regwrite pulses.

Verification
REQ-023 Reset 2 cycles, release -> state=0, irwrite=1, pcen=1, alusrcb=01, alucontrol=010; next cycle state=1.
REQ-024 op=100011 -> states 0,1,2,3,4,0; MEMRD iord=1; MEMWB memtoreg=1, regwrite=1; regwrite=0 in all other cycles.
REQ-025 op=000100: BRANCH with zero=1 -> pcen=1, pcsrc=01, alucontrol=110; zero=0 -> pcen=0. op=000101 gives the inverse pcen.
REQ-026 op=000000, funct=101010 -> EXECUTE alucontrol=111; ALUWB regdst=1, regwrite=1; back to FETCH after 4 cycles.
REQ-027 op=101011, reset raised in MEMWR cycle -> memwrite=0 that cycle, state=0 next edge. Program addi 20, addi 30, addi 0, beq taken, sw 20($0) -> exactly one memwrite pulse, and no EXECUTE for the skipped add.
REQ-028 op=111111 -> states 0,1,0; memwrite, regwrite and pcen stay 0 in DECODE.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Control/datapath bundle for the multicycle controller: instruction fields and ALU flag in, datapath controls out.
// The datapath side is the master (it drives op/funct/zero); the controller is the slave.
interface multicycle_control_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pcen;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;

    modport master (
        output op, funct, zero,
        input  pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, pcsrc, alucontrol, state
    );

    modport slave (
        input  op, funct, zero,
        output pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, pcsrc, alucontrol, state
    );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control FSM; Moore-decoded controls, pcen combinational in zero.
// One state per cycle, no backpressure; reset abandons the in-flight instruction with all controls held at 0.
module multicycle_control (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.slave  bus
);
    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } state_e;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYP = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_e state_q, state_d;

    logic       pcwrite, branch;
    logic [1:0] aluop;
    logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alu_dec;
    logic       take_branch;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:   state_d = DECODE;
            DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW:   state_d = MEMADR;
                    OP_RTYP:        state_d = EXECUTE;
                    OP_BEQ, OP_BNE: state_d = BRANCH;
                    OP_ADDI:        state_d = ADDIEX;
                    OP_J:           state_d = JUMP;
                    default:        state_d = FETCH;
                endcase
            end
            MEMADR:  state_d = (bus.op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   state_d = MEMWB;
            EXECUTE: state_d = ALUWB;
            ADDIEX:  state_d = ADDIWB;
            default: state_d = FETCH;
        endcase
    end

    // Moore output decode; unlisted controls stay at their 0 default.
    always_comb begin
        pcwrite  = 1'b0;
        branch   = 1'b0;
        aluop    = 2'b00;
        iord     = 1'b0;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        regwrite = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        case (state_q)
            FETCH: begin
                irwrite = 1'b1;
                pcwrite = 1'b1;
                alusrcb = 2'b01;
            end
            DECODE:  alusrcb = 2'b11;
            MEMADR, ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            MEMRD:   iord = 1'b1;
            MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            EXECUTE: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            ADDIWB:  regwrite = 1'b1;
            BRANCH: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        alu_dec = 3'b010;
        case (aluop)
            2'b01: alu_dec = 3'b110;
            2'b10: begin
                case (bus.funct)
                    6'b100010: alu_dec = 3'b110;
                    6'b100100: alu_dec = 3'b000;
                    6'b100101: alu_dec = 3'b001;
                    6'b101010: alu_dec = 3'b111;
                    default:   alu_dec = 3'b010;
                endcase
            end
            default: alu_dec = 3'b010;
        endcase
    end

    // bne inverts the sense of the zero flag.
    assign take_branch = branch & (bus.zero ^ (bus.op == OP_BNE));

    // Reset gates every control so an abandoned instruction cannot write anything.
    assign bus.pcen       = ~reset & (pcwrite | take_branch);
    assign bus.iord       = ~reset & iord;
    assign bus.memwrite   = ~reset & memwrite;
    assign bus.irwrite    = ~reset & irwrite;
    assign bus.regdst     = ~reset & regdst;
    assign bus.memtoreg   = ~reset & memtoreg;
    assign bus.regwrite   = ~reset & regwrite;
    assign bus.alusrca    = ~reset & alusrca;
    assign bus.alusrcb    = reset ? 2'b00 : alusrcb;
    assign bus.pcsrc      = reset ? 2'b00 : pcsrc;
    assign bus.alucontrol = reset ? 3'b000 : alu_dec;
    assign bus.state      = state_q;
endmodule
